// File: rtl/mem_access_unit.sv
// Memory stage: data-memory loads/stores and 16/32-bit stack push/pop against a
// 16-bit-wide memory. 32-bit accesses take two cycles, and upstream is stalled for the first one.
module mem_access_unit #(
  parameter int                ADDR_W  = 12,
  parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_memRead,
  input  logic              i_memWrite,
  input  logic              i_isStack,
  input  logic              i_en32,
  input  logic [3:0]        i_wb,
  input  logic [2:0]        i_rdst,
  input  logic [15:0]       i_aluData,
  input  logic [15:0]       i_storeData,
  input  logic [31:0]       i_pc,
  output logic              o_stall,
  output logic              o_valid,
  output logic [3:0]        o_wb,
  output logic [2:0]        o_rdst,
  output logic [15:0]       o_aluData,
  output logic [31:0]       o_memData,
  output logic [ADDR_W-1:0] o_sp
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SECOND = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] ONE_C = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] TWO_C = ADDR_W'(2'd2);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d, addr2_q, addr2_d;
  logic [15:0]       first_q, first_d, lo_q, lo_d;
  logic              ctx_rd_q, ctx_rd_d, ctx_stk_q, ctx_stk_d;
  logic [3:0]        ctx_wb_q, ctx_wb_d;
  logic [2:0]        ctx_rdst_q, ctx_rdst_d;
  logic [15:0]       ctx_alu_q, ctx_alu_d;
  logic              valid_q, valid_d;
  logic [3:0]        wb_q, wb_d;
  logic [2:0]        rdst_q, rdst_d;
  logic [15:0]       alu_q, alu_d;
  logic [31:0]       md_q, md_d;

  logic [15:0]       mem_q [0:(2**ADDR_W)-1];
  logic [ADDR_W-1:0] addr_s, a_s;
  logic              we_s, access_s, stall_s;
  logic [15:0]       wdata_s, rd_word_s;

  assign a_s       = i_aluData[ADDR_W-1:0];
  assign access_s  = i_valid & (i_memRead ^ i_memWrite);
  assign rd_word_s = mem_q[addr_s];

  // Access address, write strobe/data and stack pointer update for this cycle.
  always_comb begin
    addr_s  = addr2_q;
    we_s    = 1'b0;
    wdata_s = lo_q;
    sp_d    = sp_q;
    addr2_d = addr2_q;
    case (state_q)
      S_IDLE: begin
        if (access_s) begin
          if (i_isStack) begin
            if (i_memRead) begin
              addr_s  = sp_q + ONE_C;
              sp_d    = sp_q + ONE_C;
              addr2_d = sp_q + TWO_C;
            end else begin
              addr_s  = sp_q;
              sp_d    = sp_q - ONE_C;
              addr2_d = sp_q - ONE_C;
            end
          end else begin
            addr_s  = a_s;
            addr2_d = a_s + ONE_C;
          end
          we_s    = i_memWrite;
          wdata_s = i_en32 ? i_pc[31:16] : i_storeData;
        end else begin
          addr_s = a_s;
        end
      end
      S_SECOND: begin
        addr_s  = addr2_q;
        we_s    = ~ctx_rd_q;
        wdata_s = lo_q;
        if (ctx_stk_q) begin
          sp_d = ctx_rd_q ? (sp_q + ONE_C) : (sp_q - ONE_C);
        end else begin
          sp_d = sp_q;
        end
      end
      default: begin
        addr_s = addr2_q;
      end
    endcase
  end

  // Next state, latched 32-bit context and writeback-side register inputs.
  always_comb begin
    state_d    = state_q;
    stall_s    = 1'b0;
    first_d    = first_q;
    lo_d       = lo_q;
    ctx_rd_d   = ctx_rd_q;
    ctx_stk_d  = ctx_stk_q;
    ctx_wb_d   = ctx_wb_q;
    ctx_rdst_d = ctx_rdst_q;
    ctx_alu_d  = ctx_alu_q;
    valid_d    = 1'b0;
    wb_d       = 4'h0;
    rdst_d     = 3'd0;
    alu_d      = 16'h0000;
    md_d       = 32'h0000_0000;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          if (access_s & i_en32) begin
            stall_s    = 1'b1;
            state_d    = S_SECOND;
            first_d    = rd_word_s;
            lo_d       = i_pc[15:0];
            ctx_rd_d   = i_memRead;
            ctx_stk_d  = i_isStack;
            ctx_wb_d   = i_wb;
            ctx_rdst_d = i_rdst;
            ctx_alu_d  = i_aluData;
          end else begin
            valid_d = 1'b1;
            wb_d    = i_wb;
            rdst_d  = i_rdst;
            alu_d   = i_aluData;
            md_d    = (access_s & i_memRead) ? {16'h0000, rd_word_s} : 32'h0000_0000;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SECOND: begin
        state_d = S_IDLE;
        valid_d = 1'b1;
        wb_d    = ctx_wb_q;
        rdst_d  = ctx_rdst_q;
        alu_d   = ctx_alu_q;
        if (ctx_rd_q) begin
          // Pop32 reads low then high; load32 reads high then low.
          md_d = ctx_stk_q ? {rd_word_s, first_q} : {first_q, rd_word_s};
        end else begin
          md_d = 32'h0000_0000;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, stack pointer, context and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sp_q       <= SP_INIT;
      addr2_q    <= '0;
      first_q    <= 16'h0000;
      lo_q       <= 16'h0000;
      ctx_rd_q   <= 1'b0;
      ctx_stk_q  <= 1'b0;
      ctx_wb_q   <= 4'h0;
      ctx_rdst_q <= 3'd0;
      ctx_alu_q  <= 16'h0000;
      valid_q    <= 1'b0;
      wb_q       <= 4'h0;
      rdst_q     <= 3'd0;
      alu_q      <= 16'h0000;
      md_q       <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      addr2_q    <= addr2_d;
      first_q    <= first_d;
      lo_q       <= lo_d;
      ctx_rd_q   <= ctx_rd_d;
      ctx_stk_q  <= ctx_stk_d;
      ctx_wb_q   <= ctx_wb_d;
      ctx_rdst_q <= ctx_rdst_d;
      ctx_alu_q  <= ctx_alu_d;
      valid_q    <= valid_d;
      wb_q       <= wb_d;
      rdst_q     <= rdst_d;
      alu_q      <= alu_d;
      md_q       <= md_d;
    end
  end

  // Data memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[addr_s] <= wdata_s;
    end
  end

  assign o_stall   = stall_s;
  assign o_valid   = valid_q;
  assign o_wb      = wb_q;
  assign o_rdst    = rdst_q;
  assign o_aluData = alu_q;
  assign o_memData = md_q;
  assign o_sp      = sp_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected writeback records are queued as
// each instruction is driven and compared when the output register loads.
module tb_mem_access_unit;

  logic        clk, rst;
  logic        i_valid, i_memRead, i_memWrite, i_isStack, i_en32;
  logic [3:0]  i_wb;
  logic [2:0]  i_rdst;
  logic [15:0] i_aluData, i_storeData;
  logic [31:0] i_pc;
  logic        o_stall, o_valid;
  logic [3:0]  o_wb;
  logic [2:0]  o_rdst;
  logic [15:0] o_aluData;
  logic [31:0] o_memData;
  logic [11:0] o_sp;

  typedef struct {
    logic        v;
    logic [3:0]  wb;
    logic [2:0]  rdst;
    logic [15:0] alu;
    logic [31:0] md;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mem_access_unit #(.ADDR_W(12), .SP_INIT(12'hFFF)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_memRead(i_memRead),
    .i_memWrite(i_memWrite), .i_isStack(i_isStack), .i_en32(i_en32),
    .i_wb(i_wb), .i_rdst(i_rdst), .i_aluData(i_aluData),
    .i_storeData(i_storeData), .i_pc(i_pc), .o_stall(o_stall),
    .o_valid(o_valid), .o_wb(o_wb), .o_rdst(o_rdst), .o_aluData(o_aluData),
    .o_memData(o_memData), .o_sp(o_sp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_sp(input logic [11:0] exp);
    chk("sp", 32'(o_sp), 32'(exp));
  endtask

  // Check o_stall against the driven inputs, queue expectation, then compare after the edge.
  task automatic cyc(input exp_t e, input logic exp_stall);
    exp_t got;
    #1;
    chk("stall", 32'(o_stall), 32'(exp_stall));
    q.push_back(e);
    @(posedge clk);
    #1;
    got = q.pop_front();
    chk("valid", 32'(o_valid), 32'(got.v));
    chk("wb", 32'(o_wb), 32'(got.wb));
    chk("memData", o_memData, got.md);
    if (got.v) begin
      chk("rdst", 32'(o_rdst), 32'(got.rdst));
      chk("aluData", 32'(o_aluData), 32'(got.alu));
    end
  endtask

  task automatic op(input logic v, input logic rd, input logic wr, input logic stk,
                    input logic e32, input logic [3:0] wb, input logic [2:0] rdst,
                    input logic [15:0] alu, input logic [15:0] sd, input logic [31:0] pc,
                    input logic [31:0] md);
    exp_t e, b;
    i_valid = v; i_memRead = rd; i_memWrite = wr; i_isStack = stk; i_en32 = e32;
    i_wb = wb; i_rdst = rdst; i_aluData = alu; i_storeData = sd; i_pc = pc;
    e.v = v; e.wb = v ? wb : 4'h0; e.rdst = rdst; e.alu = alu; e.md = md;
    b.v = 1'b0; b.wb = 4'h0; b.rdst = 3'd0; b.alu = 16'h0000; b.md = 32'h0;
    if (v & (rd ^ wr) & e32) begin
      cyc(b, 1'b1);
      cyc(e, 1'b0);
    end else begin
      cyc(e, 1'b0);
    end
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; i_memRead = 1'b0; i_memWrite = 1'b0; i_isStack = 1'b0;
    i_en32 = 1'b0; i_wb = 4'h0; i_rdst = 3'd0; i_aluData = 16'h0;
    i_storeData = 16'h0; i_pc = 32'h0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_wb", 32'(o_wb), 32'd0);
    chk("rst_rdst", 32'(o_rdst), 32'd0);
    chk("rst_alu", 32'(o_aluData), 32'd0);
    chk("rst_md", o_memData, 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk_sp(12'hFFF);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b1;

    // 16-bit store then load
    op(1, 0, 1, 0, 0, 4'h3, 3'd1, 16'h0010, 16'hBEEF, 32'h0, 32'h0);
    op(1, 1, 0, 0, 0, 4'h5, 3'd2, 16'h0010, 16'h0, 32'h0, 32'h0000BEEF);
    chk_sp(12'hFFF);

    // 32-bit push / layout / pop
    op(1, 0, 1, 1, 1, 4'h1, 3'd0, 16'h0000, 16'h0, 32'h12345678, 32'h0);
    chk_sp(12'hFFD);
    op(1, 1, 0, 0, 0, 4'h2, 3'd3, 16'h0FFF, 16'h0, 32'h0, 32'h00001234);
    op(1, 1, 0, 0, 0, 4'h2, 3'd3, 16'h0FFE, 16'h0, 32'h0, 32'h00005678);
    op(1, 1, 0, 1, 1, 4'h9, 3'd4, 16'h0000, 16'h0, 32'h0, 32'h12345678);
    chk_sp(12'hFFF);

    // wrap-around of SP and of 32-bit address
    op(1, 0, 1, 0, 0, 4'h0, 3'd0, 16'h0000, 16'h5A5A, 32'h0, 32'h0);
    op(1, 1, 0, 1, 0, 4'h4, 3'd5, 16'h0000, 16'h0, 32'h0, 32'h00005A5A);
    chk_sp(12'h000);
    op(1, 0, 1, 1, 0, 4'h0, 3'd0, 16'h0000, 16'hAAAA, 32'h0, 32'h0);
    chk_sp(12'hFFF);
    op(1, 1, 0, 0, 0, 4'h6, 3'd1, 16'h0000, 16'h0, 32'h0, 32'h0000AAAA);
    op(1, 1, 0, 0, 1, 4'h7, 3'd2, 16'h0FFF, 16'h0, 32'h0, 32'h1234AAAA);

    // read+write pass-through and bubble
    op(1, 1, 1, 1, 1, 4'hA, 3'd6, 16'h0FFF, 16'hDEAD, 32'hDEADDEAD, 32'h0);
    chk_sp(12'hFFF);
    op(1, 1, 0, 0, 0, 4'h2, 3'd3, 16'h0FFF, 16'h0, 32'h0, 32'h00001234);
    op(0, 1, 0, 0, 1, 4'hF, 3'd7, 16'h0010, 16'h0, 32'h0, 32'h0);
    chk_sp(12'hFFF);

    // back-to-back 32-bit store/load, then push16 followed by pop16
    op(1, 0, 1, 0, 1, 4'h0, 3'd0, 16'h0020, 16'h0, 32'hCAFEF00D, 32'h0);
    op(1, 1, 0, 0, 1, 4'hB, 3'd5, 16'h0020, 16'h0, 32'h0, 32'hCAFEF00D);
    op(1, 1, 0, 0, 0, 4'hC, 3'd6, 16'h0020, 16'h0, 32'h0, 32'h0000CAFE);
    op(1, 0, 1, 1, 0, 4'h0, 3'd0, 16'h0000, 16'h7777, 32'h0, 32'h0);
    chk_sp(12'hFFE);
    op(1, 1, 0, 1, 0, 4'hD, 3'd7, 16'h0000, 16'h0, 32'h0, 32'h00007777);
    chk_sp(12'hFFF);

    // reset asserted while a push32 is in its second cycle
    op(1, 0, 1, 0, 0, 4'h0, 3'd0, 16'h0FFE, 16'h0BAD, 32'h0, 32'h0);
    begin
      exp_t b;
      b.v = 1'b0; b.wb = 4'h0; b.rdst = 3'd0; b.alu = 16'h0000; b.md = 32'h0;
      i_valid = 1'b1; i_memRead = 1'b0; i_memWrite = 1'b1; i_isStack = 1'b1;
      i_en32 = 1'b1; i_wb = 4'h8; i_rdst = 3'd1; i_aluData = 16'h0;
      i_pc = 32'h99991111;
      cyc(b, 1'b1);
    end
    chk_sp(12'hFFE);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk_reset_outputs();
    @(posedge clk); #1;
    chk_reset_outputs();
    rst = 1'b1;
    op(1, 1, 0, 0, 0, 4'h3, 3'd2, 16'h0FFF, 16'h0, 32'h0, 32'h00009999);
    op(1, 1, 0, 0, 0, 4'h3, 3'd2, 16'h0FFE, 16'h0, 32'h0, 32'h00000BAD);
    chk_sp(12'hFFF);

    idle_inputs();
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
